i2c_bus_arbiter: RTL and testbench
==================================

// Module: i2c_bus_arbiter
// PURPOSE
//  Shares one open-drain I2C bus (SCL/SDA pin pair) between NREQ I2C master cores,
//  e.g. the TMP101 poller plus other sensor masters on the same board bus.
//  Round-robin grant; a grant is held for a whole transaction and issued only after
//  the bus is seen idle. Bus lines use *_t = 1 release (high-Z) and *_t = 0 drive low.
// PARAMETERS
//  NREQ            2          number of requesting masters (2..8)
//  IDLE_CYCLES     200        clk cycles SCL&SDA must read high before a grant (>=1)
//  TIMEOUT_CYCLES  2_500_000  max grant length in clk cycles (only with I2C_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1     system clock
//  reset_n       in   1     asynchronous, active-low reset
//  req           in   NREQ  bus request, held high for the full transaction
//  gnt           out  NREQ  one-hot grant, registered
//  m_sda_t       in   NREQ  per-master SDA release/drive
//  m_scl_t       in   NREQ  per-master SCL release/drive
//  sda_t         out  1     SDA to pad (1 = release)
//  scl_t         out  1     SCL to pad (1 = release)
//  sda_i         in   1     SDA from pad (async; also fanned out to every master)
//  scl_i         in   1     SCL from pad (async; also fanned out to every master)
//  busy          out  1     a grant is active
//  timeout_flag  out  NREQ  sticky: master k was forcibly released
//  flag_clr      in   1     one-cycle pulse, clears all timeout_flag bits
// BEHAVIOUR
//  - Reset: gnt=0, busy=0, sda_t=1, scl_t=1, timeout_flag=0, rr pointer=0, state IDLE.
//    Assertion is async; lines release immediately, even mid-transaction.
//  - sda_i/scl_i pass through 2-flop synchronisers. The bus-free counter increments
//    while both sync'd lines are high, clears on any low sample, saturates at
//    IDLE_CYCLES. bus_free = (count == IDLE_CYCLES).
//  - IDLE: on an edge with bus_free && |req, the winner is the first set req bit at or
//    after the rr pointer, wrapping NREQ-1 -> 0. On the same edge: gnt[w]<=1, busy<=1,
//    rr<=(w+1) mod NREQ, go to GRANT. From reset with both pins high and req stable,
//    gnt rises on edge IDLE_CYCLES+3.
//  - GRANT: sda_t=m_sda_t[w], scl_t=m_scl_t[w] (comb. mux on registered w, no added
//    latency). Non-granted m_*_t are ignored. Changes on other req bits are ignored.
//    When req[w]==0 is sampled: gnt<=0, busy<=0, lines forced to 1, bus-free counter
//    cleared, go to IDLE. Back-to-back grants are always separated by IDLE_CYCLES.
//  - A req bit dropped before it is granted is never granted. An external master
//    holding a line low blocks all grants.
//  - RECOVER (timeout only): gnt=0, lines released. Go to IDLE once req[w]==0 is
//    sampled.
// CONFIGURATION
//  I2C_ARB_TIMEOUT_EN defined: a counter runs in GRANT. Reaching TIMEOUT_CYCLES gives
//    gnt<=0, busy<=0, timeout_flag[w]<=1, state RECOVER. Set wins over a simultaneous
//    flag_clr.
//  Undefined: no counter, timeout_flag tied 0, RECOVER unreachable, flag_clr ignored.
// STRUCTURE
//  Package i2c_arb_pkg: state encoding (IDLE/GRANT/RECOVER), LINE_RELEASE=1'b1,
//    function for the rr winner search.
//  Sub-module i2c_bus_idle_det: synchronisers plus bus-free counter, outputs bus_free.
// TESTING (NREQ=2, IDLE_CYCLES=4, TIMEOUT_CYCLES=100)
//  1 Pins high, req=01 from reset -> gnt=01 on edge 7. Drop req -> gnt=00 next edge,
//    sda_t=scl_t=1.
//  2 req=11 held -> gnt=01. Drop req[0] -> gnt=00, >=4 idle cycles, then gnt=10.
//    Re-raise req[0] and release req[1] -> gnt=01 (alternation).
//  3 gnt=10: toggle m_sda_t[0]=0 -> sda_t stays 1. m_sda_t[1]=0 -> sda_t=0 in the
//    same cycle. Same check for SCL.
//  4 Hold sda_i=0 with req=01 -> no grant. Release -> gnt=01 exactly 7 edges later.
//    A 1-cycle low glitch during counting restarts the count.
//  5 (TIMEOUT_EN) Hold req=01 -> gnt drops after 100 GRANT cycles, timeout_flag=01,
//    no regrant while req[0]=1. Drop req -> IDLE. flag_clr -> flag=00. Without the
//    macro -> grant held indefinitely.
//  6 Assert reset_n=0 mid-grant with m_scl_t[0]=0 -> scl_t=1 and gnt=00 immediately.
//    After release, rr pointer=0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C bus arbiter: FSM encoding, line levels and
// the round-robin winner search.
package i2c_arb_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_RECOVER = 2'd2;

   // Open-drain convention: *_t = 1 releases the line, 0 pulls it low.
   localparam logic LINE_RELEASE = 1'b1;

   localparam int MAX_REQ = 8;

   // First set request bit at or after ptr, wrapping n-1 -> 0.
   // Returns ptr when no bit is set; callers only use it when |req.
   function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0] ptr,
                                          input int unsigned n);
      logic [2:0]  win;
      logic        found;
      int unsigned idx;
      win   = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         idx = (32'(ptr) + i) % n;
         if (!found && (i < n) && req[idx[2:0]]) begin
            win   = idx[2:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

   // Pointer to the master after w, modulo n.
   function automatic logic [2:0] rr_next(input logic [2:0] w, input int unsigned n);
      return ((32'(w) + 32'd1) == n) ? 3'd0 : (w + 3'd1);
   endfunction

endpackage

// File: rtl/i2c_bus_idle_det.sv
// Bus-idle detector: synchronises the asynchronous SDA/SCL pad inputs and
// counts consecutive cycles with both lines high, saturating at IDLE_CYCLES.
module i2c_bus_idle_det #(
   parameter int IDLE_CYCLES = 200
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sda_i,
   input  logic scl_i,
   input  logic clr,
   output logic bus_free
);

   localparam int CW = $clog2(IDLE_CYCLES + 1);

   logic [1:0]    sda_sync;
   logic [1:0]    scl_sync;
   logic [CW-1:0] cnt;

   // Two-flop synchronisers; reset low so the count starts only once real samples arrive.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sda_sync <= 2'b00;
         scl_sync <= 2'b00;
      end else begin
         sda_sync <= {sda_sync[0], sda_i};
         scl_sync <= {scl_sync[0], scl_i};
      end
   end

   // Consecutive-high counter; any low sample or an end-of-grant clear restarts it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr || !(sda_sync[1] && scl_sync[1])) begin
         cnt <= '0;
      end else if (cnt != CW'(IDLE_CYCLES)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bus_free = (cnt == CW'(IDLE_CYCLES));

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one open-drain I2C bus between NREQ masters.
// A grant is issued only after the bus has read idle for IDLE_CYCLES and is
// held until the owner drops its request.
// Optional feature: define I2C_ARB_TIMEOUT_EN to forcibly release a grant
// after TIMEOUT_CYCLES and record it in timeout_flag.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int IDLE_CYCLES    = 200,
   parameter int TIMEOUT_CYCLES = 2_500_000
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   input  logic [NREQ-1:0] m_sda_t,
   input  logic [NREQ-1:0] m_scl_t,
   output logic            sda_t,
   output logic            scl_t,
   input  logic            sda_i,
   input  logic            scl_i,
   output logic            busy,
   output logic [NREQ-1:0] timeout_flag,
   input  logic            flag_clr,
   output logic [1:0]      fsm_state
);

   logic [1:0]         state;
   logic [NREQ-1:0]    owner;      // one-hot owner, kept through RECOVER
   logic [2:0]         rr;
   logic [2:0]         win;
   logic [NREQ-1:0]    win_oh;
   logic [MAX_REQ-1:0] req_pad;
   logic               req_w;
   logic               bus_free;
   logic               bus_clr;
   logic               t_hit;
   logic               sda_m;
   logic               scl_m;

   assign fsm_state = state;

   i2c_bus_idle_det #(
      .IDLE_CYCLES(IDLE_CYCLES)
   ) u_idle_det (
      .clk     (clk),
      .reset_n (reset_n),
      .sda_i   (sda_i),
      .scl_i   (scl_i),
      .clr     (bus_clr),
      .bus_free(bus_free)
   );

   // Round-robin winner among current requests, as index and one-hot.
   always_comb begin
      req_pad              = '0;
      req_pad[NREQ-1:0]    = req;
      win                  = rr_pick(req_pad, rr, 32'(NREQ));
      win_oh               = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (3'(k) == win) win_oh[k] = 1'b1;
      end
   end

   assign req_w   = |(req & owner);
   assign bus_clr = (state != ST_IDLE) && !req_w;

   // Pad mux: only the granted master reaches the pins; released otherwise.
   always_comb begin
      sda_m = LINE_RELEASE;
      scl_m = LINE_RELEASE;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            sda_m = m_sda_t[k];
            scl_m = m_scl_t[k];
         end
      end
   end

   assign sda_t = sda_m;
   assign scl_t = scl_m;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;

   assign t_hit = (state == ST_GRANT) && req_w && (tcnt == TW'(TIMEOUT_CYCLES - 1));

   // Grant-length counter: zero while idle, counts every cycle spent in GRANT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tcnt <= '0;
      end else if (state == ST_GRANT) begin
         tcnt <= tcnt + 1'b1;
      end else begin
         tcnt <= '0;
      end
   end

   // Sticky timeout flags; a new timeout wins over a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout_flag <= '0;
      end else begin
         timeout_flag <= (flag_clr ? '0 : timeout_flag) | (t_hit ? owner : '0);
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg   = flag_clr | (TIMEOUT_CYCLES < 1);
   assign t_hit        = 1'b0;
   assign timeout_flag = '0;
`endif

   // Arbitration FSM: IDLE -> GRANT on a free bus, back to IDLE when the owner lets go.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         gnt   <= '0;
         owner <= '0;
         busy  <= 1'b0;
         rr    <= 3'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus_free && (|req)) begin
                  gnt   <= win_oh;
                  owner <= win_oh;
                  busy  <= 1'b1;
                  rr    <= rr_next(win, 32'(NREQ));
                  state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!req_w) begin
                  gnt   <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (t_hit) begin
                  gnt   <= '0;
                  busy  <= 1'b0;
                  state <= ST_RECOVER;
               end
            end
            ST_RECOVER: begin
               if (!req_w) state <= ST_IDLE;
            end
            default: begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter (NREQ=2, IDLE_CYCLES=4,
// TIMEOUT_CYCLES=100). Build with or without I2C_ARB_TIMEOUT_EN.
module tb_i2c_bus_arbiter;

   localparam int NREQ = 2;
   localparam int IDLE = 4;
   localparam int TMO  = 100;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] m_sda_t = '1;
   logic [NREQ-1:0] m_scl_t = '1;
   logic            sda_t, scl_t;
   logic            sda_i = 1'b1;
   logic            scl_i = 1'b1;
   logic            busy;
   logic [NREQ-1:0] timeout_flag;
   logic            flag_clr = 1'b0;
   logic [1:0]      dbg_state;

   i2c_bus_arbiter #(
      .NREQ(NREQ), .IDLE_CYCLES(IDLE), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt),
      .m_sda_t(m_sda_t), .m_scl_t(m_scl_t), .sda_t(sda_t), .scl_t(scl_t),
      .sda_i(sda_i), .scl_i(scl_i), .busy(busy), .timeout_flag(timeout_flag),
      .flag_clr(flag_clr), .fsm_state(dbg_state)
   );

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Bus-free rule: the sync'd view of the pins lags by two edges; a grant
   // is allowed once IDLE consecutive counted edges passed since the last
   // edge that saw a low (or ended a grant).
   int              m_edge = 0;
   int              m_last_zero = 0;
   int              m_owner = 0;
   int              m_rr = 0;
   int              m_gcnt = 0;
   bit              m_grant = 1'b0;
   bit              m_recover = 1'b0;
   bit              m_ph1 = 1'b0;
   bit              m_ph2 = 1'b0;
   logic [NREQ-1:0] m_gnt = '0;
   logic [NREQ-1:0] m_flag = '0;

   always @(posedge clk or negedge reset_n) begin : ref_model
      bit free;
      bit set_flag;
      bit found;
      int idx;
      if (!reset_n) begin
         m_edge = 0; m_last_zero = 0; m_owner = 0; m_rr = 0; m_gcnt = 0;
         m_grant = 1'b0; m_recover = 1'b0; m_ph1 = 1'b0; m_ph2 = 1'b0;
         m_gnt = '0; m_flag = '0;
      end else begin
         m_edge++;
         free = ((m_edge - 1 - m_last_zero) >= IDLE);
         set_flag = 1'b0;
         if (m_grant) begin
            if (!req[m_owner]) begin
               m_grant = 1'b0; m_gnt = '0; m_last_zero = m_edge;
            end else begin
               m_gcnt++;
               if (TO_EN && m_gcnt == TMO) begin
                  m_grant = 1'b0; m_recover = 1'b1; m_gnt = '0; set_flag = 1'b1;
               end
            end
         end else if (m_recover) begin
            if (!req[m_owner]) begin
               m_recover = 1'b0; m_last_zero = m_edge;
            end
         end else if (free && req != '0) begin
            found = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
               idx = (m_rr + i) % NREQ;
               if (!found && req[idx]) begin found = 1'b1; m_owner = idx; end
            end
            m_gnt = '0; m_gnt[m_owner] = 1'b1;
            m_rr = (m_owner + 1) % NREQ;
            m_grant = 1'b1; m_gcnt = 0;
         end
         if (TO_EN) begin
            if (flag_clr) m_flag = '0;
            if (set_flag) m_flag[m_owner] = 1'b1;
         end
         if (!m_ph2) m_last_zero = m_edge;
         m_ph2 = m_ph1;
         m_ph1 = sda_i & scl_i;
      end
   end

   // ---------------- scoreboard: every cycle on the falling edge ----------------
   always @(negedge clk) begin
      if (check_en) begin
         check("gnt", gnt, m_gnt);
         check("busy", busy, m_grant);
         check("timeout_flag", timeout_flag, m_flag);
         check("sda_t", sda_t, m_grant ? m_sda_t[m_owner] : 1'b1);
         check("scl_t", scl_t, m_grant ? m_scl_t[m_owner] : 1'b1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
   endtask

   task automatic wait_gnt(input logic [NREQ-1:0] want, input int limit, output int n);
      n = 0;
      while (gnt !== want && n < limit) begin
         cyc(1);
         n++;
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      check_en = 1'b1;

      // 1: single requester from reset, grant on edge IDLE+3
      req = 2'b01;
      do_reset();
      check("rst_gnt", gnt, 2'b00);
      check("rst_lines", {sda_t, scl_t}, 2'b11);
      cyc(6);
      check("t1_gnt_e6", gnt, 2'b00);
      cyc(1);
      check("t1_gnt_e7", gnt, 2'b01);
      req = 2'b00;
      cyc(1);
      check("t1_drop", gnt, 2'b00);
      check("t1_lines", {sda_t, scl_t}, 2'b11);

      // 2: alternation with enforced idle gap
      req = 2'b11;
      do_reset();
      wait_gnt(2'b01, 20, n);
      check("t2_first", gnt, 2'b01);
      req = 2'b10;
      cyc(1);
      check("t2_rel", gnt, 2'b00);
      wait_gnt(2'b10, 20, n);
      check("t2_second", gnt, 2'b10);
      check("t2_gap", n, IDLE + 1);
      req = 2'b01;
      wait_gnt(2'b01, 20, n);
      check("t2_alt", gnt, 2'b01);

      // 3: only the granted master reaches the pins
      req = 2'b10;
      wait_gnt(2'b10, 20, n);
      check("t3_gnt", gnt, 2'b10);
      m_sda_t = 2'b10; #1;
      check("t3_sda_other", sda_t, 1'b1);
      m_sda_t = 2'b01; #1;
      check("t3_sda_owner", sda_t, 1'b0);
      m_sda_t = 2'b11;
      m_scl_t = 2'b10; #1;
      check("t3_scl_other", scl_t, 1'b1);
      m_scl_t = 2'b01; #1;
      check("t3_scl_owner", scl_t, 1'b0);
      m_scl_t = 2'b11;
      cyc(1);

      // 4: external low blocks grants; a glitch restarts the count
      req = 2'b00;
      cyc(2);
      sda_i = 1'b0;
      req = 2'b01;
      cyc(20);
      check("t4_blocked", gnt, 2'b00);
      sda_i = 1'b1;
      wait_gnt(2'b01, 20, n);
      check("t4_lat", n, 7);
      req = 2'b00;
      cyc(1);
      sda_i = 1'b0;
      req = 2'b01;
      cyc(3);
      sda_i = 1'b1;
      cyc(3);
      sda_i = 1'b0;
      cyc(1);
      sda_i = 1'b1;
      wait_gnt(2'b01, 20, n);
      check("t4_glitch_lat", n, 7);

      // 5: long grant (forced release only with the timeout feature)
      n = 0;
      while (gnt === 2'b01 && n < 300) begin
         cyc(1);
         n++;
      end
      if (TO_EN) begin
         check("t5_len", n, TMO);
         check("t5_flag", timeout_flag, 2'b01);
         m_sda_t = 2'b00; #1;
         check("t5_recover_sda", sda_t, 1'b1);
         m_sda_t = 2'b11;
         cyc(20);
         check("t5_no_regrant", gnt, 2'b00);
      end else begin
         check("t5_held", gnt, 2'b01);
         check("t5_flag0", timeout_flag, 2'b00);
      end
      req = 2'b00;
      cyc(10);
      flag_clr = 1'b1;
      cyc(1);
      flag_clr = 1'b0;
      check("t5_clr", timeout_flag, 2'b00);

      // 6: async reset mid-grant releases lines at once and resets rr
      req = 2'b01;
      wait_gnt(2'b01, 30, n);
      check("t6_gnt", gnt, 2'b01);
      m_scl_t = 2'b10;
      cyc(1);
      check("t6_scl_low", scl_t, 1'b0);
      reset_n = 1'b0; #1;
      check("t6_rst_scl", scl_t, 1'b1);
      check("t6_rst_gnt", gnt, 2'b00);
      check("t6_rst_busy", busy, 1'b0);
      cyc(2);
      m_scl_t = 2'b11;
      req = 2'b11;
      reset_n = 1'b1;
      wait_gnt(2'b01, 20, n);
      check("t6_rr0", gnt, 2'b01);

      // random traffic against the reference model
      for (int i = 0; i < 4000; i++) begin
         cyc(1);
         for (int b = 0; b < NREQ; b++) begin
            if ($urandom_range(0, 19) == 0) req[b] = ~req[b];
         end
         m_sda_t  = NREQ'($urandom_range(0, 3));
         m_scl_t  = NREQ'($urandom_range(0, 3));
         sda_i    = ($urandom_range(0, 29) != 0);
         scl_i    = ($urandom_range(0, 29) != 0);
         flag_clr = ($urandom_range(0, 49) == 0);
      end
      flag_clr = 1'b0;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
